// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: FSM state encoding and 2-bit BHT counter values.
package bru_pkg;

  typedef enum logic {
    BRU_IDLE     = 1'b0,
    BRU_REDIRECT = 1'b1
  } bru_state_t;

  localparam logic [1:0] SNT       = 2'b00;
  localparam logic [1:0] WNT       = 2'b01;
  localparam logic [1:0] WT        = 2'b10;
  localparam logic [1:0] ST        = 2'b11;
  localparam logic [1:0] BHT_RESET = WNT;

  // Saturating 2-bit counter step toward the observed direction.
  function automatic logic [1:0] bht_step(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken && cur != ST) nxt = cur + 2'd1;
    else if (!taken && cur != SNT) nxt = cur - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bru_bht.sv
// Branch history table: array of 2-bit saturating counters, one combinational read port, one update port.
// Read returns the pre-update value when read and write hit the same entry in a cycle (no bypass).
module bru_bht
  import bru_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_taken,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic            wr_taken
);

  localparam int IDXW = $clog2(ENTRIES);

  logic [1:0]      ctr [ENTRIES];
  logic [IDXW-1:0] rd_idx;
  logic [IDXW-1:0] wr_idx;

  assign rd_idx   = rd_pc[IDXW+1:2];
  assign wr_idx   = wr_pc[IDXW+1:2];
  assign rd_taken = ctr[rd_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= BHT_RESET;
    end else if (wr_en) begin
      ctr[wr_idx] <= bht_step(ctr[wr_idx], wr_taken);
    end
  end

  // PC bits outside the index field carry no information for the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{rd_pc[XLEN-1:IDXW+2], rd_pc[1:0], wr_pc[XLEN-1:IDXW+2], wr_pc[1:0]};

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX branches/jumps against the fetch prediction, trains the BHT, raises a held redirect plus 1-cycle flush.
// Redirect appears 1 cycle after a mispredicting resolve and is held (EX stalled) until redirect_ready; BRU_PERF_EN adds perf counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic            br_sig,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            ex_stall,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  bru_state_t state, state_nxt;
  logic       resolve;
  logic       actual;
  logic       mispred;
  logic       train;

  assign resolve = ex_valid & (ex_is_branch | ex_is_jump) & (state == BRU_IDLE);
  assign actual  = ex_is_jump | (ex_is_branch & br_sig);
  assign mispred = (actual != ex_pred_taken) |
                   (actual & ex_pred_taken & (ex_target != ex_pred_target));
  // A simultaneous branch+jump encoding is handled as a jump and never trains.
  assign train   = resolve & ex_is_branch & ~ex_is_jump;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BRU_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BRU_IDLE:     if (resolve && mispred) state_nxt = BRU_REDIRECT;
      BRU_REDIRECT: if (redirect_ready)     state_nxt = BRU_IDLE;
      default:      state_nxt = BRU_IDLE;
    endcase
  end

  assign redirect_valid = (state == BRU_REDIRECT);
  assign ex_stall       = (state == BRU_REDIRECT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush <= resolve & mispred;
      if (resolve && mispred) redirect_pc <= actual ? ex_target : ex_pc + XLEN'(4);
    end
  end

  bru_bht #(
    .XLEN    (XLEN),
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_pc    (if_pc),
    .rd_taken (if_pred_taken),
    .wr_en    (train),
    .wr_pc    (ex_pc),
    .wr_taken (actual)
  );

`ifdef BRU_PERF_EN
  logic [31:0] perf_br_q;
  logic [31:0] perf_mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else if (resolve) begin
      perf_br_q <= perf_br_q + 32'd1;
      if (mispred) perf_mis_q <= perf_mis_q + 32'd1;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule
